// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the imem_loader (IMEM_LOADER_CHECKSUM_EN adds ST_CSUM)
package imem_loader_pkg;

   localparam int LEN_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;
   localparam int LEN_W          = 8 * LEN_BYTES;
   localparam int WORD_W         = 8 * BYTES_PER_WORD;

   typedef enum logic [2:0] {
      ST_LEN_LO = 3'd0,
      ST_LEN_HI = 3'd1,
      ST_DATA   = 3'd2,
      ST_WRITE  = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERR    = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      ST_CSUM   = 3'd6
`endif
   } state_t;

endpackage

// File: rtl/imem_loader_byte_to_word_packer.sv
// rtl/imem_loader_byte_to_word_packer.sv - little-endian byte-to-word shift register with byte counter
module byte_to_word_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              i_clear,
   input  logic              i_valid,
   input  logic [7:0]        i_byte,
   output logic [WORD_W-1:0] o_word,
   output logic              o_word_full
);

   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

   logic [WORD_W-1:0] r_word;
   logic [1:0]        r_cnt;

   // Shift new bytes in from the top so the first byte lands in bits [7:0].
   always_ff @(posedge clk) begin
      if (i_clear) begin
         r_word <= '0;
         r_cnt  <= 2'd0;
      end else if (i_valid) begin
         r_word <= {i_byte, r_word[WORD_W-1:8]};
         r_cnt  <= r_cnt + 2'd1;
      end
   end

   assign o_word      = r_word;
   assign o_word_full = i_valid && (r_cnt == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte-stream loader into instruction memory (optional IMEM_LOADER_CHECKSUM_EN)
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          DEPTH_WORDS = 64,
   parameter logic [63:0] BASE_ADDR   = 64'd0
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic        imem_we,
   output logic [63:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_hold,
   output logic        done,
   output logic        error,
   input  logic        reload
);

   localparam int               IDX_W   = $clog2(DEPTH_WORDS + 1);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH_WORDS);

   state_t             r_state;
   state_t             w_next;
   logic               r_active;
   logic [7:0]         r_len_lo;
   logic [LEN_W-1:0]   r_len;
   logic [IDX_W-1:0]   r_word_idx;

   logic               w_ready;
   logic               w_accept;
   logic               w_reload;
   logic               w_clear;
   logic               w_pack_valid;
   logic               w_word_full;
   logic [WORD_W-1:0]  w_word;
   logic [LEN_W-1:0]   w_len_n;
   logic [LEN_W-1:0]   w_idx_next;
   logic               w_last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]         r_csum;
`endif

   assign w_accept     = s_valid && w_ready;
   assign w_reload     = reload && ((r_state == ST_DONE) || (r_state == ST_ERR));
   assign w_clear      = !reset || w_reload;
   assign w_pack_valid = w_accept && (r_state == ST_DATA);
   assign w_len_n      = {s_data, r_len_lo};
   assign w_idx_next   = LEN_W'(r_word_idx) + LEN_W'(1);
   assign w_last_word  = (w_idx_next == r_len);
   assign s_ready      = w_ready;

   byte_to_word_packer u_packer (
      .clk         (clk),
      .i_clear     (w_clear),
      .i_valid     (w_pack_valid),
      .i_byte      (s_data),
      .o_word      (w_word),
      .o_word_full (w_word_full)
   );

   // r_active holds s_ready low through the reset cycle and releases it one edge later.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_active <= 1'b0;
      end else begin
         r_active <= 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_LEN_LO;
      end else begin
         r_state <= w_next;
      end
   end

   // Length capture and word index; reset and reload both start a fresh image.
   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_len_lo   <= 8'd0;
         r_len      <= '0;
         r_word_idx <= '0;
      end else begin
         if ((r_state == ST_LEN_LO) && w_accept) begin
            r_len_lo <= s_data;
         end
         if ((r_state == ST_LEN_HI) && w_accept) begin
            r_len <= w_len_n;
         end
         if (r_state == ST_WRITE) begin
            r_word_idx <= r_word_idx + IDX_W'(1);
         end
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   // Running modulo-256 sum of data bytes only; length bytes never reach it.
   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_csum <= 8'd0;
      end else if (w_pack_valid) begin
         r_csum <= r_csum + s_data;
      end
   end
`endif

   // Byte acceptance is a pure function of state so s_ready never follows s_valid.
   always_comb begin
      w_ready = 1'b0;
      case (r_state)
         ST_LEN_LO, ST_LEN_HI, ST_DATA: w_ready = r_active;
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CSUM:                       w_ready = r_active;
`endif
         default:                       w_ready = 1'b0;
      endcase
   end

   // Next-state logic and state-decoded outputs.
   always_comb begin
      w_next     = r_state;
      imem_we    = 1'b0;
      imem_addr  = BASE_ADDR + {{(64-IDX_W-2){1'b0}}, r_word_idx, 2'b00};
      imem_wdata = w_word;
      core_hold  = 1'b1;
      done       = 1'b0;
      error      = 1'b0;
      case (r_state)
         ST_LEN_LO: begin
            if (w_accept) begin
               w_next = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (w_accept) begin
               if (w_len_n == '0) begin
                  w_next = ST_DONE;
               end else if (w_len_n > MAX_LEN) begin
                  w_next = ST_ERR;
               end else begin
                  w_next = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (w_word_full) begin
               w_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            imem_we = 1'b1;
            if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               w_next = ST_CSUM;
`else
               w_next = ST_DONE;
`endif
            end else begin
               w_next = ST_DATA;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CSUM: begin
            if (w_accept) begin
               w_next = (s_data == r_csum) ? ST_DONE : ST_ERR;
            end
         end
`endif
         ST_DONE: begin
            core_hold = 1'b0;
            done      = 1'b1;
            if (reload) begin
               w_next = ST_LEN_LO;
            end
         end
         ST_ERR: begin
            error = 1'b1;
            if (reload) begin
               w_next = ST_LEN_LO;
            end
         end
         default: begin
            w_next = ST_LEN_LO;
         end
      endcase
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with randomized images and a reference model
module tb_imem_loader;

   localparam int          DEPTH = 64;
   localparam logic [63:0] BASE  = 64'hFFFF_FFFF_FFFF_FFF0;

   typedef struct {
      logic [63:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic        imem_we;
   logic [63:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_hold;
   logic        done;
   logic        error;
   logic        reload;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          last_acc_edge = 0;
   int          last_we_cyc = 0;

   logic [7:0]  img_q[$];
   wr_t         exp_q[$];
   int          exp_n;
   bit          exp_done;
   bit          exp_err;
   int          send_len;

   imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk        (clk),
      .reset      (reset),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_hold  (core_hold),
      .done       (done),
      .error      (error),
      .reload     (reload)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Scoreboard monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (reset === 1'b1 && imem_we === 1'b1) begin
         last_we_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual addr=%h data=%h required no write", imem_addr, imem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", imem_addr, e.addr);
            chk("wr_data", 64'(imem_wdata), 64'(e.data));
            chk("we_latency", 64'(cyc), 64'(last_acc_edge));
         end
      end
   end

   // Reference model: parse the image with plain arithmetic and queue the expected writes.
   task automatic model();
      int sum;
      int b;
      logic [31:0] w;
      exp_n    = int'(img_q[0]) + 256 * int'(img_q[1]);
      exp_done = 1'b0;
      exp_err  = 1'b0;
      sum      = 0;
      if (exp_n == 0) begin
         exp_done = 1'b1;
         send_len = 2;
      end else if (exp_n > DEPTH) begin
         exp_err  = 1'b1;
         send_len = 2;
      end else begin
         for (int i = 0; i < exp_n; i++) begin
            b = 2 + 4 * i;
            w = {img_q[b+3], img_q[b+2], img_q[b+1], img_q[b]};
            sum += int'(img_q[b]) + int'(img_q[b+1]) + int'(img_q[b+2]) + int'(img_q[b+3]);
            exp_q.push_back('{addr: BASE + 64'(4 * i), data: w});
         end
         send_len = 2 + 4 * exp_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
         send_len = send_len + 1;
         if (img_q[send_len-1] == 8'(sum)) exp_done = 1'b1;
         else exp_err = 1'b1;
`else
         exp_done = 1'b1;
`endif
      end
   endtask

   task automatic build_image(input int n, input bit bad_csum);
      int sum;
      logic [7:0] by;
      img_q.delete();
      sum = 0;
      img_q.push_back(n[7:0]);
      img_q.push_back(n[15:8]);
      if (n <= DEPTH) begin
         for (int i = 0; i < 4 * n; i++) begin
            by = 8'($urandom_range(0, 255));
            sum += int'(by);
            img_q.push_back(by);
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (n > 0) img_q.push_back(bad_csum ? 8'(sum + 1) : 8'(sum));
`endif
      end
      if (bad_csum && n > DEPTH) $display("note: checksum flag ignored for oversize image");
   endtask

   task automatic set_two_word();
      img_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
      img_q.push_back(8'hA0);
`endif
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps, input bit try_reload);
      int w;
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      s_data  = b;
      s_valid = 1'b1;
      reload  = try_reload;
      w = 0;
      while (s_ready !== 1'b1 && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual s_ready=%b required 1 within 100 cycles", s_ready);
      end
      last_acc_edge = cyc + 1;
      @(negedge clk);
      s_valid = 1'b0;
      reload  = 1'b0;
      s_data  = 8'($urandom_range(0, 255));
   endtask

   task automatic wait_outcome(input string tag);
      int k;
      int exp_cyc;
      k = 0;
      while (!(done === 1'b1 || error === 1'b1) && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (k >= 60) begin
         checks++;
         errors++;
         $display("FAIL %s_outcome_timeout actual done=%b error=%b required an outcome", tag, done, error);
      end
      chk({tag, "_done"}, 64'(done), 64'(exp_done));
      chk({tag, "_error"}, 64'(error), 64'(exp_err));
      chk({tag, "_core_hold"}, 64'(core_hold), 64'(!exp_done));
      chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
      chk({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
      if (exp_n == 0 || exp_n > DEPTH) exp_cyc = last_acc_edge;
      else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
         exp_cyc = last_acc_edge;
`else
         exp_cyc = last_we_cyc + 1;
`endif
      end
      chk({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
      exp_q.delete();
      s_valid = 1'b1;
      s_data  = 8'hEE;
      repeat (3) @(negedge clk);
      chk({tag, "_no_accept_after"}, 64'(s_ready), 64'd0);
      chk({tag, "_outcome_stable"}, 64'({done, error}), 64'({exp_done, exp_err}));
      s_valid = 1'b0;
   endtask

   task automatic run_image(input string tag, input bit gaps, input int reload_at);
      model();
      for (int i = 0; i < send_len; i++) send_byte(img_q[i], gaps, i == reload_at);
      wait_outcome(tag);
   endtask

   task automatic do_reload();
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      chk("reload_s_ready", 64'(s_ready), 64'd1);
      chk("reload_core_hold", 64'(core_hold), 64'd1);
      chk("reload_done", 64'(done), 64'd0);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
      chk({tag, "_imem_we"}, 64'(imem_we), 64'd0);
      chk({tag, "_imem_addr"}, imem_addr, BASE);
      chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
      chk({tag, "_core_hold"}, 64'(core_hold), 64'd1);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_error"}, 64'(error), 64'd0);
   endtask

   initial begin
      int ns[7] = '{1, 3, 64, 65, 256, 17, 5};
      reset   = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'h00;
      reload  = 1'b0;
      repeat (3) @(negedge clk);
      reset_checks("rst");
      reset = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 64'(s_ready), 64'd1);

      set_two_word();
      run_image("two_word", 1'b0, -1);

      do_reload();
      img_q = '{8'h00, 8'h00};
      run_image("empty", 1'b0, -1);

      do_reload();
      img_q = '{8'h41, 8'h00};
      run_image("oversize", 1'b0, -1);

      do_reload();
      set_two_word();
      run_image("backpressure", 1'b1, -1);

      do_reload();
      send_byte(8'h02, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h13, 1'b0, 1'b0);
      send_byte(8'h05, 1'b0, 1'b0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset_checks("midrst");
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_ready_after", 64'(s_ready), 64'd1);
      set_two_word();
      run_image("after_midrst", 1'b0, -1);

`ifdef IMEM_LOADER_CHECKSUM_EN
      do_reload();
      set_two_word();
      img_q[img_q.size()-1] = 8'hA1;
      run_image("csum_bad", 1'b0, -1);
      do_reload();
      set_two_word();
      run_image("csum_good", 1'b0, -1);
      do_reload();
      build_image(6, 1'b1);
      run_image("csum_rand_bad", 1'b1, -1);
`endif

      foreach (ns[i]) begin
         do_reload();
         build_image(ns[i], 1'b0);
         run_image($sformatf("rand%0d", ns[i]), 1'b1, 4);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that fills the instruction memory of the single-cycle RISC-V core before it runs. It accepts a length-prefixed little-endian image over a valid/ready byte interface and packs the bytes into 32-bit instruction words. It writes those words to consecutive instruction-memory addresses while holding the core in reset, then releases the core.

## Interface
- DEPTH_WORDS, 64, instruction-memory capacity in 32-bit words; the maximum accepted image length.
- BASE_ADDR, 64'd0, byte address of the first written word.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- s_data  in  8  stream byte.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  loader accepts a byte; a transfer happens when s_valid and s_ready are both high.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  64  write byte address.
- imem_wdata  out  32  write word.
- core_hold  out  1  1 = keep the processor in reset.
- done  out  1  image loaded and core released.
- error  out  1  load rejected.
- reload  in  1  restart the load; honoured only in DONE or ERR.

## Operation
- Image format:
  - LEN_LO, then LEN_HI, form the 16-bit word count N.
  - Then 4·N data bytes, least-significant byte of each word first.
- States:
  - LEN_LO: capture the low length byte, go to LEN_HI.
  - LEN_HI:
    - N == 0: go to DONE.
    - N > DEPTH_WORDS: go to ERR.
    - Otherwise: go to DATA.
  - DATA: shift each accepted byte into the word buffer and count bytes 0..3. On the 4th byte, go to WRITE.
  - WRITE (one cycle):
    - imem_we = 1, imem_addr = BASE_ADDR + 4·word_idx, imem_wdata = assembled word. Then word_idx++.
    - If word_idx reaches N, go to DONE (or CSUM with checksum enabled). Otherwise return to DATA.
  - DONE: core_hold = 0, done = 1. On reload, go to LEN_LO.
  - ERR: core_hold = 1, error = 1. On reload, go to LEN_LO.
- Signal decode:
  - s_ready = 1 only in LEN_LO, LEN_HI, DATA and CSUM. It is decoded from state alone and never depends on s_valid.
  - core_hold = 1 in every state except DONE.
- Arithmetic:
  - word_idx is clog2(DEPTH_WORDS+1) bits wide and zero-extended before the ×4.
  - The address add wraps modulo 2^64.
- Reload behaviour: reload clears word_idx, the byte counter, the length and the checksum. Reload outside DONE/ERR is ignored.
- Reset mid-load:
  - Go to LEN_LO and discard any partial word; no write is issued for it.
  - Words already written are not undone.

## Timing
- Reset values (while reset = 0 and in the cycle it is sampled):
  - s_ready = 0, imem_we = 0, imem_addr = BASE_ADDR, imem_wdata = 0.
  - core_hold = 1, done = 0, error = 0, state = LEN_LO.
- s_ready = 1 from the first cycle after reset returns high.
- Data path: 4th byte of a word accepted in cycle t → imem_we high in cycle t+1 for exactly one cycle.
- Last word: imem_we in cycle t+1 → done = 1 and core_hold = 0 in cycle t+2 (without checksum).
- Throughput: at most one word per 5 cycles. The byte offered during WRITE is held by the source until s_ready returns.
- Length byte: LEN_HI accepted in cycle t → DONE or ERR in cycle t+1 when applicable.
- All outputs are registered or decoded from registered state; there are no combinational input→output paths.

## Configuration
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, enter CSUM and accept one extra byte.
  - That byte must equal the sum of all data bytes modulo 256; the length bytes are excluded.
  - Match → DONE; mismatch → ERR.
- Undefined: CSUM state and the sum register are absent, and the last WRITE goes directly to DONE.

## Structure
- Package imem_loader_pkg:
  - state enum
  - LEN_BYTES = 2
  - BYTES_PER_WORD = 4
- Sub-module byte_to_word_packer:
  - shift register plus 2-bit byte counter.
  - Outputs the little-endian word and a word_full pulse.
  - Cleared by the top-level clear (reset or reload).

## Test plan
- Two-word load: stream 02 00 13 05 A0 00 93 05 50 00.
  - Writes 0x00A00513 @ BASE+0, then 0x00500593 @ BASE+4.
  - Then done = 1, core_hold = 0, s_ready = 0.
- Empty image: stream 00 00 → DONE one cycle after LEN_HI, no imem_we.
- Oversize: stream 41 00 with DEPTH_WORDS = 64 → ERR; error = 1, core_hold = 1, no writes, following bytes not accepted.
- Backpressure: the two-word load with s_valid randomly deasserted.
  - Identical writes to the two-word load.
  - No byte lost or duplicated across WRITE cycles.
- Reset mid-load: reset after 2 data bytes of word 1, then a full two-word load.
  - No write with the partial word.
  - Final writes are correct.
- Checksum (macro defined):
  - Two-word load followed by A0 → DONE.
  - Same load followed by A1 → ERR.
  - reload from ERR, then a correct image → DONE.
